// File: rtl/fmul_result_pack.sv
// Result packing stage behind the FMUL multiply core: sign/class delay line, exponent
// range correction, IEEE-754 packing and a credit-controlled output FIFO. Optional FMUL_STATS_EN adds flag counters.
module fmul_result_pack #(
  parameter int unsigned MUL_LAT   = 2,
  parameter int unsigned OUT_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [7:0]  mul_exp,
  input  logic [22:0] mul_man,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [3:0]  flags
`ifdef FMUL_STATS_EN
  ,
  output logic [15:0] stat_ovf,
  output logic [15:0] stat_unf,
  output logic [15:0] stat_inv
`endif
);

  typedef enum logic [1:0] {
    CLS_NORM,
    CLS_ZERO,
    CLS_INF,
    CLS_NAN
  } op_class_t;

  localparam int unsigned TAIL = MUL_LAT - 1;
  localparam int unsigned PW   = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int unsigned CW   = $clog2(OUT_DEPTH + MUL_LAT + 1) + 1;

  function automatic op_class_t classify(input logic [31:0] x);
    if (x[30:23] == 8'hFF) begin
      return (x[22:0] != 23'd0) ? CLS_NAN : CLS_INF;
    end else if (x[30:23] == 8'h00) begin
      return CLS_ZERO;
    end
    return CLS_NORM;
  endfunction

  // Input side: classification and biased exponent sum
  op_class_t   cls_a, cls_b, in_cls;
  logic        in_sign;
  logic [9:0]  in_esum;
  logic        accept;

  always_comb begin
    cls_a   = classify(op_a);
    cls_b   = classify(op_b);
    in_sign = op_a[31] ^ op_b[31];
    in_esum = {2'b00, op_a[30:23]} + {2'b00, op_b[30:23]} - 10'd126;
    in_cls  = CLS_NORM;
    if (cls_a == CLS_NAN || cls_b == CLS_NAN ||
        (cls_a == CLS_INF && cls_b == CLS_ZERO) ||
        (cls_a == CLS_ZERO && cls_b == CLS_INF)) begin
      in_cls = CLS_NAN;
    end else if (cls_a == CLS_INF || cls_b == CLS_INF) begin
      in_cls = CLS_INF;
    end else if (cls_a == CLS_ZERO || cls_b == CLS_ZERO) begin
      in_cls = CLS_ZERO;
    end
  end

  assign accept = in_valid & in_ready;

  // Delay line shadowing the core; it never stalls
  logic        dl_v    [MUL_LAT];
  logic        dl_sign [MUL_LAT];
  op_class_t   dl_cls  [MUL_LAT];
  logic [9:0]  dl_esum [MUL_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < MUL_LAT; k++) begin
        dl_v[k]    <= 1'b0;
        dl_sign[k] <= 1'b0;
        dl_cls[k]  <= CLS_NORM;
        dl_esum[k] <= '0;
      end
    end else begin
      dl_v[0]    <= accept;
      dl_sign[0] <= in_sign;
      dl_cls[0]  <= in_cls;
      dl_esum[0] <= in_esum;
      for (int unsigned k = 1; k < MUL_LAT; k++) begin
        dl_v[k]    <= dl_v[k-1];
        dl_sign[k] <= dl_sign[k-1];
        dl_cls[k]  <= dl_cls[k-1];
        dl_esum[k] <= dl_esum[k-1];
      end
    end
  end

  logic [CW-1:0] inflight;

  always_comb begin
    inflight = '0;
    for (int unsigned k = 0; k < MUL_LAT; k++) begin
      inflight = inflight + {{(CW-1){1'b0}}, dl_v[k]};
    end
  end

  // Tail: recover the true exponent from the core's wrapped 8-bit one
  logic [7:0]  t_adj;
  logic [9:0]  t_exp;
  logic [31:0] pk_res;
  logic [3:0]  pk_flags;
  logic        push;

  assign push = dl_v[TAIL];

  always_comb begin
    t_adj    = dl_esum[TAIL][7:0] - mul_exp;
    t_exp    = dl_esum[TAIL] - {2'b00, t_adj};
    pk_res   = '0;
    pk_flags = '0;
    unique case (dl_cls[TAIL])
      CLS_NAN: begin
        pk_res   = 32'h7FC0_0000;
        pk_flags = 4'b1000;
      end
      CLS_INF: begin
        pk_res = {dl_sign[TAIL], 8'hFF, 23'd0};
      end
      CLS_ZERO: begin
        pk_res   = {dl_sign[TAIL], 31'd0};
        pk_flags = 4'b0001;
      end
      default: begin
        if ($signed(t_exp) >= 10'sd255) begin
          pk_res   = {dl_sign[TAIL], 8'hFF, 23'd0};
          pk_flags = 4'b0100;
        end else if ($signed(t_exp) <= 10'sd0) begin
          pk_res   = {dl_sign[TAIL], 31'd0};
          pk_flags = 4'b0011;
        end else begin
          pk_res = {dl_sign[TAIL], t_exp[7:0], mul_man};
        end
      end
    endcase
  end

  norm_adjust_range: assert property (@(posedge clk) disable iff (!rst_n)
    (dl_v[TAIL] && dl_cls[TAIL] == CLS_NORM) |-> (t_adj <= 8'd1));

  // Output FIFO; credit accounting guarantees room for every push
  logic [35:0]   fifo_mem [OUT_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_cnt;
  logic [CW-1:0] occupancy;
  logic          pop;

  assign pop = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {pk_res, pk_flags};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_comb begin
    occupancy = inflight + fifo_cnt;
    in_ready  = occupancy < CW'(OUT_DEPTH);
    out_valid = fifo_cnt != '0;
    result    = '0;
    flags     = '0;
    if (out_valid) begin
      result = fifo_mem[rd_ptr][35:4];
      flags  = fifo_mem[rd_ptr][3:0];
    end
  end

`ifdef FMUL_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ovf <= '0;
      stat_unf <= '0;
      stat_inv <= '0;
    end else if (push) begin
      if (pk_flags[2] && stat_ovf != '1) stat_ovf <= stat_ovf + 16'd1;
      if (pk_flags[1] && stat_unf != '1) stat_unf <= stat_unf + 16'd1;
      if (pk_flags[3] && stat_inv != '1) stat_inv <= stat_inv + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fmul_result_pack.sv
// Bench for fmul_result_pack: emulates the multiply core, checks every output against a
// float-arithmetic reference queue plus directed vectors, credit, latency and reset cases.
module tb_fmul_result_pack;
  localparam int unsigned MUL_LAT   = 2;
  localparam int unsigned OUT_DEPTH = 4;
  localparam int unsigned LAT       = MUL_LAT + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [7:0]  mul_exp = '0;
  logic [22:0] mul_man = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic [3:0]  flags;
`ifdef FMUL_STATS_EN
  logic [15:0] stat_ovf, stat_unf, stat_inv;
  int          m_ovf = 0, m_unf = 0, m_inv = 0;
`endif

  fmul_result_pack #(.MUL_LAT(MUL_LAT), .OUT_DEPTH(OUT_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .mul_exp(mul_exp), .mul_man(mul_man),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags)
`ifdef FMUL_STATS_EN
    , .stat_ovf(stat_ovf), .stat_unf(stat_unf), .stat_inv(stat_inv)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Exact 24x24 significand product, normalized and truncated
  function automatic void norm_product(input logic [31:0] a, input logic [31:0] b,
                                       output int e, output logic [22:0] m);
    logic [47:0] p;
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      e = e + 1;
      m = p[46:24];
    end else begin
      m = p[45:23];
    end
  endfunction

  function automatic logic [35:0] ref_model(input logic [31:0] a, input logic [31:0] b);
    int ea, eb, e;
    logic [22:0] m;
    logic s;
    bit na, nb, ia, ib, za, zb;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    na = (ea == 255) && (a[22:0] != 0);
    nb = (eb == 255) && (b[22:0] != 0);
    ia = (ea == 255) && (a[22:0] == 0);
    ib = (eb == 255) && (b[22:0] == 0);
    za = (ea == 0);
    zb = (eb == 0);
    if (na || nb || (ia && zb) || (za && ib)) return {32'h7FC0_0000, 4'b1000};
    if (ia || ib) return {s, 8'hFF, 23'd0, 4'b0000};
    if (za || zb) return {s, 31'd0, 4'b0001};
    norm_product(a, b, e, m);
    if (e >= 255) return {s, 8'hFF, 23'd0, 4'b0100};
    if (e <= 0) return {s, 31'd0, 4'b0011};
    return {s, e[7:0], m, 4'b0000};
  endfunction

  function automatic logic [30:0] core_out(input logic [31:0] a, input logic [31:0] b);
    int e;
    logic [22:0] m;
    norm_product(a, b, e, m);
    return {e[7:0], m};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] x;
    x = $urandom;
    case ($urandom_range(0, 15))
      0:       x[30:23] = 8'h00;
      1:       x[30:23] = 8'hFF;
      2:       begin x[30:23] = 8'hFF; x[22:0] = '0; end
      3:       x[30:23] = 8'($urandom_range(200, 254));
      4:       x[30:23] = 8'($urandom_range(1, 50));
      default: x[30:23] = 8'($urandom_range(64, 190));
    endcase
    return x;
  endfunction

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
    int          acc_cyc;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flg;
  } vec_t;

  exp_t        sb[$];
  logic [30:0] core_pipe [MUL_LAT];
  int          cyc = 0;
  logic        s_acc, s_in_ready, s_out_valid, popped;
  logic [31:0] s_result, last_res;
  logic [3:0]  s_flags, last_flg;

  // One clock: sample and check at negedge, then advance the core model after the edge
  task automatic step();
    logic [35:0] r;
    int now;
    @(negedge clk);
    now         = cyc;
    s_acc       = rst_n && in_valid && in_ready;
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    s_result    = result;
    s_flags     = flags;
    popped      = 1'b0;
    if (rst_n) begin
      check("in_ready", in_ready, sb.size() < OUT_DEPTH);
      check("out_valid", out_valid, sb.size() > 0 && sb[0].acc_cyc + LAT <= now);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("stale_output", out_valid, 0);
        end else begin
          check("result", result, sb[0].res);
          check("flags", flags, sb[0].flg);
          popped   = 1'b1;
          last_res = result;
          last_flg = flags;
          void'(sb.pop_front());
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int k = MUL_LAT - 1; k > 0; k--) core_pipe[k] = core_pipe[k-1];
    core_pipe[0] = s_acc ? core_out(op_a, op_b) : 31'($urandom);
    if (s_acc) begin
      r = ref_model(op_a, op_b);
      sb.push_back('{res: r[35:4], flg: r[3:0], acc_cyc: now});
`ifdef FMUL_STATS_EN
      m_ovf += int'(r[2]);
      m_unf += int'(r[1]);
      m_inv += int'(r[3]);
`endif
    end
    mul_exp = core_pipe[MUL_LAT-1][30:23];
    mul_man = core_pipe[MUL_LAT-1][22:0];
  endtask

  task automatic drain(input int budget);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < budget && sb.size() > 0; k++) step();
    check("drain_done", sb.size(), 0);
  endtask

  vec_t vecs[15];

  initial begin
    int n_acc, n_pop, lat;
    logic [31:0] got[2];
    int pcyc[2];

    vecs[0]  = '{32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000};
    vecs[1]  = '{32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000};
    vecs[2]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0100};
    vecs[3]  = '{32'h00800000, 32'h00800000, 32'h00000000, 4'b0011};
    vecs[4]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000};
    vecs[5]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000};
    vecs[6]  = '{32'h00000001, 32'h3F800000, 32'h00000000, 4'b0001};
    vecs[7]  = '{32'h80000000, 32'h3F800000, 32'h80000000, 4'b0001};
    vecs[8]  = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b1000};
    vecs[9]  = '{32'h7F000000, 32'h3F800000, 32'h7F000000, 4'b0000};
    vecs[10] = '{32'h7F400000, 32'h3FC00000, 32'h7F800000, 4'b0100};
    vecs[11] = '{32'h00800000, 32'h3F800000, 32'h00800000, 4'b0000};
    vecs[12] = '{32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011};
    vecs[13] = '{32'h80000000, 32'hFF800000, 32'h7FC00000, 4'b1000};
    vecs[14] = '{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 4'b0000};

    for (int k = 0; k < MUL_LAT; k++) core_pipe[k] = '0;

    // Reset state
    step();
    step();
    check("reset_in_ready", s_in_ready, 1);
    check("reset_out_valid", s_out_valid, 0);
    check("reset_result", s_result, 0);
    check("reset_flags", s_flags, 0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step();

    // Directed vectors, one at a time
    foreach (vecs[i]) begin
      op_a     = vecs[i].a;
      op_b     = vecs[i].b;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      lat      = 0;
      popped   = 1'b0;
      for (int k = 0; k < 10 && !popped; k++) begin
        step();
        lat++;
      end
      check("vec_popped", popped, 1);
      check("vec_latency", lat, LAT);
      check("vec_result", last_res, vecs[i].res);
      check("vec_flags", last_flg, vecs[i].flg);
    end

    // Back-to-back issue
    in_valid = 1'b1;
    op_a = vecs[0].a; op_b = vecs[0].b;
    step();
    op_a = vecs[1].a; op_b = vecs[1].b;
    step();
    in_valid = 1'b0;
    n_pop = 0;
    for (int k = 0; k < 10 && n_pop < 2; k++) begin
      step();
      if (popped) begin
        got[n_pop]  = last_res;
        pcyc[n_pop] = cyc;
        n_pop++;
      end
    end
    check("b2b_count", n_pop, 2);
    check("b2b_first", got[0], 32'h40400000);
    check("b2b_second", got[1], 32'hC0C00000);
    check("b2b_spacing", pcyc[1] - pcyc[0], 1);

    // Credit: consumer stalled, upstream holding valid for 6 ops
    out_ready = 1'b0;
    in_valid  = 1'b1;
    op_a = rand_op(); op_b = rand_op();
    n_acc = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (s_acc) begin
        n_acc++;
        op_a = rand_op(); op_b = rand_op();
      end
    end
    check("credit_accepts", n_acc, OUT_DEPTH);
    check("credit_block", in_ready, 0);
    out_ready = 1'b1;
    n_pop = 0;
    for (int k = 0; k < 12 && n_pop < 4; k++) begin
      step();
      if (popped) begin
        n_pop++;
        if (n_pop == 1) check("credit_return", in_ready, 1);
      end
    end
    check("credit_drain", n_pop, 4);
    drain(20);
`ifdef FMUL_STATS_EN
    check("stat_ovf", stat_ovf, m_ovf);
    check("stat_unf", stat_unf, m_unf);
    check("stat_inv", stat_inv, m_inv);
`endif

    // Randomized traffic
    in_valid = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (!in_valid || s_acc) begin
        in_valid = ($urandom_range(0, 9) < 7);
        op_a = rand_op(); op_b = rand_op();
      end
      out_ready = ($urandom_range(0, 9) < 6);
      step();
    end
    drain(30);

    // Reset with 2 buffered and 2 in flight
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      op_a = rand_op(); op_b = rand_op();
      step();
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    sb.delete();
`ifdef FMUL_STATS_EN
    m_ovf = 0; m_unf = 0; m_inv = 0;
`endif
    step();
    check("midrst_out_valid", s_out_valid, 0);
    check("midrst_in_ready", s_in_ready, 1);
    check("midrst_result", s_result, 0);
`ifdef FMUL_STATS_EN
    check("midrst_stat_ovf", stat_ovf, 0);
    check("midrst_stat_unf", stat_unf, 0);
    check("midrst_stat_inv", stat_inv, 0);
`endif
    rst_n     = 1'b1;
    out_ready = 1'b1;
    n_pop     = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (s_out_valid) n_pop++;
    end
    check("no_stale_after_reset", n_pop, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no summary expected summary");
    $fatal(1, "watchdog");
  end

endmodule
